// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, CSR addresses,
// cause codes, mstatus/mie bit positions and the mstatus rewrite helpers.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_REDIRECT  = 3'd4
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_EXT_IRQ   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIE_MEIE       = 11;

  // Trap entry: stash MIE into MPIE, disable interrupts, record machine mode.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline-side bundle of the trap sequencer: instruction boundary, decode flags,
// interrupt lines, CSR read values, datapath write request and arbitrated outputs.
interface trap_sequencer_if;
  import trap_sequencer_pkg::*;

  // instr_valid offers an instruction each cycle; stall=1 is the only backpressure:
  // while stall is high the sequencer ignores the offer and the pipeline must hold.
  logic        instr_valid;
  logic [31:0] pc;
  logic        ecall;
  logic        mret;
  logic        illegal;
  logic        irq_ext;
  logic        irq_timer;
  logic [31:0] mstatus_in;
  logic [31:0] mie_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        dp_wcsr_n;
  logic [11:0] dp_waddr;
  logic [31:0] dp_wdata;
  logic        wcsr_n;
  logic [11:0] wr1_addr;
  logic [31:0] data1_in;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  state_e      dbg_state;

  modport slave (
    input  instr_valid, pc, ecall, mret, illegal, irq_ext, irq_timer,
    input  mstatus_in, mie_in, mtvec_in, mepc_in, dp_wcsr_n, dp_waddr, dp_wdata,
    output wcsr_n, wr1_addr, data1_in, stall, redirect, redirect_pc, dbg_state
  );

  modport master (
    output instr_valid, pc, ecall, mret, illegal, irq_ext, irq_timer,
    output mstatus_in, mie_in, mtvec_in, mepc_in, dp_wcsr_n, dp_waddr, dp_wdata,
    input  wcsr_n, wr1_addr, data1_in, stall, redirect, redirect_pc, dbg_state
  );
endinterface

// File: rtl/trap_sequencer_irq_sync.sv
// Multi-flop synchronizer for one asynchronous level interrupt line, cleared by reset.
module irq_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_x,
  input  logic async_i,
  output logic sync_o
);
  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) sync_q <= '0;
    else          sync_q <= {sync_q[DEPTH-2:0], async_i};
  end

  assign sync_o = sync_q[DEPTH-1];
endmodule

// File: rtl/trap_sequencer.sv
// Trap/mret sequencer: serialises mepc/mcause/mstatus writes onto the single CSR
// write port, then redirects the PC. Define TRAP_VECTORED_EN for vectored interrupts.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset_x,
  trap_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        mret_q, mret_d;

  logic        ext_sync, timer_sync;
  logic        take_ext, take_timer;
  logic        evt, evt_mret;
  logic [31:0] evt_cause;
  logic [31:0] base, trap_tgt;

  logic        stall, redirect, wcsr_n;
  logic [31:0] redirect_pc, wdata;
  logic [11:0] waddr;

  irq_sync #(.DEPTH(IRQ_SYNC_STAGES)) u_sync_ext (
    .clk(clk), .reset_x(reset_x), .async_i(bus.irq_ext), .sync_o(ext_sync)
  );

  irq_sync #(.DEPTH(IRQ_SYNC_STAGES)) u_sync_timer (
    .clk(clk), .reset_x(reset_x), .async_i(bus.irq_timer), .sync_o(timer_sync)
  );

  assign take_ext   = bus.mstatus_in[MSTATUS_MIE] & bus.mie_in[MIE_MEIE] & ext_sync;
  assign take_timer = bus.mstatus_in[MSTATUS_MIE] & bus.mie_in[MIE_MTIE] & timer_sync;

  always_comb begin
    evt       = 1'b1;
    evt_mret  = 1'b0;
    evt_cause = '0;
    if (take_ext)         evt_cause = CAUSE_EXT_IRQ;
    else if (take_timer)  evt_cause = CAUSE_TIMER_IRQ;
    else if (bus.illegal) evt_cause = CAUSE_ILLEGAL;
    else if (bus.ecall)   evt_cause = CAUSE_ECALL;
    else if (bus.mret)    evt_mret  = 1'b1;
    else                  evt       = 1'b0;
  end

  assign base = {bus.mtvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  // Only interrupts vector; exceptions always land on the base address.
  assign trap_tgt = (evt_cause[31] && bus.mtvec_in[1:0] == 2'b01)
                  ? base + {evt_cause[29:0], 2'b00} : base;
`else
  assign trap_tgt = base;
`endif

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    target_d    = target_q;
    mret_d      = mret_q;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    wcsr_n      = 1'b1;
    waddr       = '0;
    wdata       = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && evt) begin
          stall    = 1'b1;
          cause_d  = evt_cause;
          pc_d     = bus.pc;
          mret_d   = evt_mret;
          target_d = evt_mret ? bus.mepc_in : trap_tgt;
          state_d  = evt_mret ? ST_W_MSTATUS : ST_W_MEPC;
        end else begin
          wcsr_n = bus.dp_wcsr_n;
          waddr  = bus.dp_waddr;
          wdata  = bus.dp_wdata;
        end
      end
      ST_W_MEPC: begin
        stall   = 1'b1;
        wcsr_n  = 1'b0;
        waddr   = CSR_MEPC;
        wdata   = pc_q;
        state_d = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        stall   = 1'b1;
        wcsr_n  = 1'b0;
        waddr   = CSR_MCAUSE;
        wdata   = cause_q;
        state_d = ST_W_MSTATUS;
      end
      ST_W_MSTATUS: begin
        stall   = 1'b1;
        wcsr_n  = 1'b0;
        waddr   = CSR_MSTATUS;
        wdata   = mret_q ? mret_mstatus(bus.mstatus_in) : trap_mstatus(bus.mstatus_in);
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = target_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs must show reset values while reset is held, not forwarded dp writes.
    if (!reset_x) begin
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      wcsr_n      = 1'b1;
      waddr       = '0;
      wdata       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      pc_q     <= '0;
      target_q <= '0;
      mret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      mret_q   <= mret_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.wcsr_n      = wcsr_n;
  assign bus.wr1_addr    = waddr;
  assign bus.data1_in    = wdata;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: a sequence-level model fills an expected queue that one
// negedge compare process drains, plus directed literal checks of the key scenarios.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  trap_sequencer_if bus();

  trap_sequencer #(.IRQ_SYNC_STAGES(2)) dut (
    .clk(clk), .reset_x(reset_x), .bus(bus)
  );

  typedef struct packed {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        wcsr_n;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic wn, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    e.stall = st; e.redirect = rd; e.rpc = rpc; e.wcsr_n = wn; e.addr = a; e.data = d;
    return e;
  endfunction

  // Interrupt lines are held stable for several cycles before any offered
  // instruction, so the model can use their raw level.
  task automatic model_eval();
    logic [31:0] cause, ms, nm, tgt;
    bit ev, is_mret;
    ev = 0; is_mret = 0; cause = 0;
    if (!bus.instr_valid) return;
    if (bus.irq_ext && bus.mstatus_in[3] && bus.mie_in[11]) begin ev = 1; cause = 32'h8000000B; end
    else if (bus.irq_timer && bus.mstatus_in[3] && bus.mie_in[7]) begin ev = 1; cause = 32'h80000007; end
    else if (bus.illegal) begin ev = 1; cause = 32'h2; end
    else if (bus.ecall)   begin ev = 1; cause = 32'hB; end
    else if (bus.mret)    is_mret = 1;
    ms = bus.mstatus_in;
    if (is_mret) begin
      nm = ms; nm[3] = ms[7]; nm[7] = 1'b1;
      exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 12'h300, nm));
      exp_q.push_back(mk(1, 1, bus.mepc_in, 1, 0, 0));
    end else if (ev) begin
      tgt = {bus.mtvec_in[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (cause[31] && bus.mtvec_in[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'h7FFFFFFF);
`endif
      nm = ms; nm[7] = ms[3]; nm[3] = 1'b0; nm[12:11] = 2'b11;
      exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 12'h341, bus.pc));
      exp_q.push_back(mk(1, 0, 0, 0, 12'h342, cause));
      exp_q.push_back(mk(1, 0, 0, 0, 12'h300, nm));
      exp_q.push_back(mk(1, 1, tgt, 1, 0, 0));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_x) begin
      exp_q.delete();
      chk("rst_stall", bus.stall, 0);
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_wcsr_n", bus.wcsr_n, 1);
    end else begin
      if (exp_q.size() == 0) model_eval();
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("seq_stall", bus.stall, e.stall);
        chk("seq_redirect", bus.redirect, e.redirect);
        chk("seq_wcsr_n", bus.wcsr_n, e.wcsr_n);
        if (!e.wcsr_n) begin
          chk("seq_addr", bus.wr1_addr, e.addr);
          chk("seq_data", bus.data1_in, e.data);
        end
        if (e.redirect) chk("seq_rpc", bus.redirect_pc, e.rpc);
      end else begin
        chk("fwd_stall", bus.stall, 0);
        chk("fwd_redirect", bus.redirect, 0);
        chk("fwd_wcsr_n", bus.wcsr_n, bus.dp_wcsr_n);
        chk("fwd_addr", bus.wr1_addr, bus.dp_waddr);
        chk("fwd_data", bus.data1_in, bus.dp_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_instr();
    bus.instr_valid = 0; bus.ecall = 0; bus.mret = 0; bus.illegal = 0;
  endtask

  // Offer one instruction and check the mcause write two cycles later; ends at T+5.
  task automatic fire(input bit ill, input bit ec, input logic [31:0] exp_cause);
    bus.instr_valid = 1; bus.illegal = ill; bus.ecall = ec;
    step(); clear_instr();
    step();
    @(negedge clk);
    chk("prio_mcause_addr", bus.wr1_addr, 12'h342);
    chk("prio_mcause_data", bus.data1_in, exp_cause);
    repeat (3) step();
  endtask

  initial begin
    clear_instr();
    bus.pc = 0; bus.irq_ext = 0; bus.irq_timer = 0;
    bus.mstatus_in = 0; bus.mie_in = 0; bus.mtvec_in = 0; bus.mepc_in = 0;
    bus.dp_wcsr_n = 1; bus.dp_waddr = 0; bus.dp_wdata = 0;
    #2;
    chk("reset_wcsr_n", bus.wcsr_n, 1);
    chk("reset_addr", bus.wr1_addr, 0);
    chk("reset_data", bus.data1_in, 0);
    chk("reset_rpc", bus.redirect_pc, 0);
    repeat (3) step();
    reset_x = 1;
    step();

    // ecall trap with a live datapath write that must be suppressed
    bus.mstatus_in = 32'h1888; bus.mtvec_in = 32'h200; bus.pc = 32'h100;
    bus.dp_wcsr_n = 0; bus.dp_waddr = 12'h340; bus.dp_wdata = 32'h1234;
    bus.instr_valid = 1; bus.ecall = 1;
    @(negedge clk);
    chk("ecall_T_stall", bus.stall, 1);
    chk("ecall_T_wcsr_n", bus.wcsr_n, 1);
    step(); clear_instr();
    @(negedge clk);
    chk("ecall_mepc_addr", bus.wr1_addr, 12'h341);
    chk("ecall_mepc_data", bus.data1_in, 32'h100);
    step(); @(negedge clk);
    chk("ecall_mcause_data", bus.data1_in, 32'hB);
    step(); @(negedge clk);
    chk("ecall_mstatus_addr", bus.wr1_addr, 12'h300);
    chk("ecall_mstatus_data", bus.data1_in, 32'h1880);
    step(); @(negedge clk);
    chk("ecall_redirect", bus.redirect, 1);
    chk("ecall_rpc", bus.redirect_pc, 32'h200);
    chk("ecall_T4_stall", bus.stall, 1);
    step(); @(negedge clk);
    chk("ecall_T5_stall", bus.stall, 0);
    bus.dp_wcsr_n = 1;

    // mret
    step();
    bus.mstatus_in = 32'h1880; bus.mepc_in = 32'h104;
    bus.instr_valid = 1; bus.mret = 1;
    @(negedge clk);
    chk("mret_T_stall", bus.stall, 1);
    step(); clear_instr();
    @(negedge clk);
    chk("mret_mstatus_wcsr_n", bus.wcsr_n, 0);
    chk("mret_mstatus_data", bus.data1_in, 32'h1888);
    step(); @(negedge clk);
    chk("mret_redirect", bus.redirect, 1);
    chk("mret_rpc", bus.redirect_pc, 32'h104);
    step(); @(negedge clk);
    chk("mret_done_stall", bus.stall, 0);

    // timer interrupt beats ecall
    bus.mstatus_in = 32'h1888; bus.mie_in = 32'h80; bus.irq_timer = 1;
    repeat (4) step();
    bus.mtvec_in = 32'h201; bus.pc = 32'h300;
    bus.instr_valid = 1; bus.ecall = 1;
    step(); clear_instr();
    step(); @(negedge clk);
    chk("timer_mcause", bus.data1_in, 32'h80000007);
    step(); step(); @(negedge clk);
`ifdef TRAP_VECTORED_EN
    chk("timer_rpc", bus.redirect_pc, 32'h21C);
`else
    chk("timer_rpc", bus.redirect_pc, 32'h200);
`endif
    step();
    bus.irq_timer = 0;
    repeat (4) step();

    // masked ext interrupt: no trap, dp write forwarded
    bus.mstatus_in = 32'h0; bus.mie_in = 32'h800; bus.irq_ext = 1;
    repeat (4) step();
    bus.instr_valid = 1; bus.pc = 32'h400;
    bus.dp_wcsr_n = 0; bus.dp_waddr = 12'h340; bus.dp_wdata = 32'hDEAD;
    @(negedge clk);
    chk("masked_stall", bus.stall, 0);
    chk("masked_wcsr_n", bus.wcsr_n, 0);
    chk("masked_addr", bus.wr1_addr, 12'h340);
    chk("masked_data", bus.data1_in, 32'hDEAD);
    step(); clear_instr(); bus.dp_wcsr_n = 1;

    // instr_valid=0 with ecall: nothing taken
    bus.ecall = 1; bus.dp_wcsr_n = 0; bus.dp_wdata = 32'h55;
    @(negedge clk);
    chk("novalid_stall", bus.stall, 0);
    chk("novalid_data", bus.data1_in, 32'h55);
    step(); clear_instr(); bus.dp_wcsr_n = 1;

    // priority chain
    bus.mstatus_in = 32'h8; bus.mie_in = 32'h880; bus.mtvec_in = 32'h1000;
    bus.irq_ext = 1; bus.irq_timer = 1; bus.pc = 32'h500;
    repeat (4) step();
    fire(1, 1, 32'h8000000B);
    bus.irq_ext = 0; repeat (4) step();
    fire(1, 1, 32'h80000007);
    bus.irq_timer = 0; repeat (4) step();
    fire(1, 1, 32'h2);
    bus.mret = 1;
    fire(0, 1, 32'hB);
    bus.mret = 0;

    // events during a sequence ignored; pending interrupt retaken back in IDLE
    bus.irq_ext = 1; repeat (4) step();
    bus.instr_valid = 1; bus.ecall = 1;
    bus.dp_wcsr_n = 0; bus.dp_waddr = 12'h7C0; bus.dp_wdata = 32'hAA;
    repeat (5) step();
    @(negedge clk);
    chk("retake_T5_stall", bus.stall, 1);
    chk("retake_T5_wcsr_n", bus.wcsr_n, 1);
    step(); step(); @(negedge clk);
    chk("retake_mcause", bus.data1_in, 32'h8000000B);
    step(); clear_instr(); bus.dp_wcsr_n = 1;
    repeat (4) step();
    bus.irq_ext = 0; repeat (4) step();

    // reset in W_MCAUSE abandons the sequence
    bus.mstatus_in = 32'h1888; bus.mtvec_in = 32'h200; bus.pc = 32'h600;
    bus.instr_valid = 1; bus.ecall = 1;
    step(); clear_instr();
    step();
    reset_x = 0;
    #1;
    chk("midrst_wcsr_n", bus.wcsr_n, 1);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_redirect", bus.redirect, 0);
    chk("midrst_rpc", bus.redirect_pc, 0);
    chk("midrst_addr", bus.wr1_addr, 0);
    chk("midrst_data", bus.data1_in, 0);
    step(); step();
    reset_x = 1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_write", bus.wcsr_n, 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter IRQ_SYNC_STAGES, default 2, SHALL set the flip-flop depth of each interrupt-line synchronizer (legal values 2..3).
REQ-002 clk  in  1  SHALL be the rising-edge clock for all state.
REQ-003 reset_x  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 instr_valid  in  1  SHALL mark a valid instruction at the boundary; pc  in  32  SHALL be its address.
REQ-005 ecall, mret, illegal  in  1 each  SHALL be decode flags for the current instruction.
REQ-006 irq_ext, irq_timer  in  1 each  SHALL be asynchronous level interrupt requests.
REQ-007 mstatus_in, mie_in, mtvec_in, mepc_in  in  32 each  SHALL be the current CSR read values.
REQ-008 dp_wcsr_n  in  1, dp_waddr  in  12, dp_wdata  in  32  SHALL be the datapath CSR write request (active-low enable).
REQ-009 wcsr_n  out  1, wr1_addr  out  12, data1_in  out  32  SHALL form the arbitrated CSR write port.
REQ-010 stall  out  1  SHALL freeze the pipeline; redirect  out  1 and redirect_pc  out  32  SHALL form a one-cycle PC redirect.

Function
REQ-011 FSM states SHALL be IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
REQ-012 In IDLE with instr_valid=1, events SHALL be prioritised: ext irq (cause 0x8000000B) > timer irq (0x80000007) > illegal (0x00000002) > ecall (0x0000000B) > mret.
REQ-013 An interrupt SHALL be taken only if mstatus_in[3]=1, the matching mie_in bit (11 ext, 7 timer) =1, and the synchronized line =1.
REQ-014 Acceptance cycle T: latch cause, pc, and target; assert stall combinationally; suppress the datapath write (wcsr_n=1).
REQ-015 Trap path: T+1 W_MEPC writes 0x341 <- latched pc; T+2 W_MCAUSE writes 0x342 <- cause; T+3 W_MSTATUS writes 0x300 <- mstatus_in with [7]=old[3], [3]=0, [12:11]=2'b11; T+4 REDIRECT; T+5 IDLE.
REQ-016 mret path: T+1 W_MSTATUS writes 0x300 <- mstatus_in with [3]=old[7], [7]=1; T+2 REDIRECT with redirect_pc = mepc_in latched at T.
REQ-017 The trap target SHALL be {mtvec_in[31:2],2'b00}, latched at T.
REQ-018 stall SHALL be 1 from T through REDIRECT inclusive; redirect SHALL be 1 only in REDIRECT.
REQ-019 In IDLE with no accepted event, wcsr_n, wr1_addr, and data1_in SHALL forward dp_* unchanged in the same cycle.
REQ-020 Events and dp writes arriving outside IDLE SHALL be ignored; level interrupts remain pending and are re-evaluated on return to IDLE.
REQ-021 With instr_valid=0, no event SHALL be accepted and forwarding SHALL continue.

Reset
REQ-022 On reset_x=0: state IDLE; stall=0, redirect=0, redirect_pc=0, wcsr_n=1, wr1_addr=0, data1_in=0; latches and synchronizers cleared.
REQ-023 Reset mid-sequence SHALL abandon the sequence with no further CSR write.

Configuration
REQ-024 Macro TRAP_VECTORED_EN: when defined and mtvec_in[1:0]=01, the interrupt target SHALL be base + 4*cause[30:0]; exceptions SHALL use base.
REQ-025 Without TRAP_VECTORED_EN, all traps SHALL use base and mtvec_in[1:0] SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state enum, CSR address constants (0x300, 0x304, 0x305, 0x341, 0x342), cause codes, and mstatus bit indices (MIE 3, MPIE 7, MPP 12:11).
REQ-027 Sub-module irq_sync (parameterised depth, async-clear) SHALL be instantiated once per interrupt line.

Verification
REQ-028 ecall, pc=0x100, mtvec=0x200, mstatus=0x1888 -> writes 0x341=0x100, 0x342=0xB, 0x300=0x1880 on T+1..T+3; redirect to 0x200 at T+4; stall high 5 cycles.
REQ-029 mret, mstatus=0x1880, mepc=0x104 -> 0x300=0x1888 at T+1; redirect to 0x104 at T+2.
REQ-030 irq_timer=1, mie[7]=1, mstatus[3]=1 together with ecall -> cause 0x80000007; with TRAP_VECTORED_EN and mtvec=0x201, target 0x21C.
REQ-031 irq_ext=1 with mstatus[3]=0 -> no trap; dp write 0x340=0xDEAD forwarded the same cycle.
REQ-032 Reset asserted at W_MCAUSE -> outputs at reset values immediately; no 0x300 write after release.
